capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Frame-level sequencer between the camera `capture` block and the frame buffer write port.
- Arms capture on command and aligns to start-of-frame (`capture.o_sof`).
- Runs single-shot or continuous with programmable frame skipping.
- Generates linear pixel addresses, and flags overflow and short frames.

Parameters:
H_ACTIVE, 640, pixels per row
V_ACTIVE, 480, rows per frame
ADDR_W, 19, frame buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
SKIP_W, 4, width of frame-skip count

Ports:
i_pclk  in  1  pixel clock; all logic on rising edge
i_rstn  in  1  reset, asynchronous, active-low
i_start  in  1  1-cycle pulse; begin capture (ignored unless IDLE)
i_continuous  in  1  1 = keep capturing after each frame; sampled at frame end
i_abort  in  1  return to IDLE immediately; highest priority
i_skip  in  SKIP_W  frames dropped between captured frames; sampled at frame end
i_sof  in  1  start-of-frame pulse from capture
i_wr  in  1  pixel valid from capture
i_wdata  in  16  pixel data from capture
i_full  in  1  frame buffer cannot accept a write this cycle
o_wr  out  1  frame buffer write strobe
o_waddr  out  ADDR_W  write address = pixel index in frame
o_wdata  out  16  write data
o_busy  out  1  state != IDLE
o_frame_done  out  1  1-cycle pulse, frame completed
o_overflow  out  1  sticky: a pixel was dropped because i_full was high
o_short_frame  out  1  sticky: i_sof arrived mid-frame
o_frame_cnt  out  8  completed-frame count, wraps 255->0

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Internal pixel counter and skip counter 0.
- Sticky flags clear only on reset or on an accepted i_start.
- Registered outputs: o_wr, o_waddr and o_wdata follow the qualifying i_wr by exactly 1 cycle.
- o_busy is registered from state; it changes the cycle after a transition.
- IDLE:
  - i_start -> ARMED; clears o_overflow and o_short_frame.
  - i_wr and i_sof are ignored.
- ARMED:
  - i_sof -> CAPTURE; pixel counter = 0.
  - i_wr is ignored.
  - If i_wr coincides with i_sof, that pixel is not captured.
- CAPTURE, on each i_wr:
  - If !i_full: o_wr=1, o_waddr=counter, o_wdata=i_wdata.
  - If i_full: no write and o_overflow set; the counter still advances to preserve geometry.
- CAPTURE, end of frame:
  - At counter = H_ACTIVE*V_ACTIVE-1, the i_wr ends the frame, whether written or dropped.
  - o_frame_done pulses in the same cycle as that pixel's o_wr slot.
  - o_frame_cnt increments.
  - Next state: if i_continuous, SKIP with skip counter = i_skip; otherwise IDLE.
- CAPTURE, i_sof before frame end:
  - o_short_frame is set; the frame restarts and counter = 0.
  - o_frame_done does not pulse and o_frame_cnt does not change.
- SKIP:
  - On i_sof with skip counter = 0 -> CAPTURE, counter = 0.
  - On i_sof with skip counter != 0 -> decrement and stay in SKIP.
  - i_skip=N therefore drops exactly N whole frames.
  - i_wr is ignored.
- Abort:
  - i_abort in any state -> IDLE next edge.
  - A pending o_wr from the previous cycle still completes; no further o_wr after that.
  - No o_frame_done; sticky flags are kept.
- Simultaneous events:
  - i_abort beats i_start, i_sof and frame end.
  - i_start while busy is ignored.
  - Deasserting i_continuous mid-frame takes effect at that frame's end.
- Counter arithmetic:
  - The pixel counter is ADDR_W bits and never exceeds H_ACTIVE*V_ACTIVE-1.
  - Extra i_wr beyond the frame (IDLE, SKIP, ARMED) produce no writes.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, i_continuous=0: start, sof, 32 random pixels -> 32 writes, addr 0..31 matching data 1 cycle later; o_frame_done with addr 31; o_frame_cnt=1; IDLE; further frames produce no writes.
- i_continuous=1, i_skip=2, 4 frames after arming: frames 1 and 4 written (2 and 3 dropped) -> o_frame_cnt=2.
- i_full high for pixels 5..7 of a frame -> no o_wr at addrs 5,6,7; pixel 8 written to addr 8; o_overflow=1; o_frame_done still pulses.
- i_sof after 20 pixels of 32 -> o_short_frame=1; next pixel written to addr 0; o_frame_done only after 32 further pixels.
- i_abort at pixel 10 -> o_busy=0 next cycle; no write for pixel 11+; o_frame_cnt unchanged; i_start then re-arms and clears flags.
- Reset asserted mid-CAPTURE -> all outputs 0 immediately (asynchronous); after release, IDLE with o_wr=0 regardless of i_wr/i_sof activity.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: pixel stream from capture plus frame buffer write port
interface capture_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              i_sof;
    logic              i_wr;
    logic [15:0]       i_wdata;
    logic              i_full;
    logic              o_wr;
    logic [ADDR_W-1:0] o_waddr;
    logic [15:0]       o_wdata;
    modport master (
        input  i_sof, i_wr, i_wdata, i_full,
        output o_wr, o_waddr, o_wdata
    );
    modport slave (
        output i_sof, i_wr, i_wdata, i_full,
        input  o_wr, o_waddr, o_wdata
    );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: frame sequencer aligning capture to sof and writing pixels linearly into the frame buffer
module capture_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int SKIP_W   = 4
) (
    input  logic              i_pclk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_abort,
    input  logic [SKIP_W-1:0] i_skip,
    capture_ctrl_if.master    bus,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overflow,
    output logic              o_short_frame,
    output logic [7:0]        o_frame_cnt
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, SKIP} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, waddr_q, waddr_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              wr_q, wr_d, busy_q, busy_d, done_q, done_d;
    logic              ovf_q, ovf_d, short_q, short_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        fcnt_d  = fcnt_q;
        ovf_d   = ovf_q;
        short_d = short_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    state_d = ARMED;
                    ovf_d   = 1'b0;
                    short_d = 1'b0;
                end
                ARMED: if (bus.i_sof) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end
                CAPTURE: if (bus.i_sof) begin
                    short_d = 1'b1;
                    cnt_d   = '0;
                end else if (bus.i_wr) begin
                    // a dropped pixel still advances the counter so later pixels keep their address
                    wr_d  = !bus.i_full;
                    ovf_d = ovf_q | bus.i_full;
                    if (!bus.i_full) begin
                        waddr_d = cnt_q;
                        wdata_d = bus.i_wdata;
                    end
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 8'd1;
                        cnt_d   = '0;
                        skip_d  = i_skip;
                        state_d = i_continuous ? SKIP : IDLE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                default: if (bus.i_sof) begin
                    if (skip_q == '0) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        skip_d = skip_q - SKIP_W'(1);
                    end
                end
            endcase
        end
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            skip_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            fcnt_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            fcnt_q  <= fcnt_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            short_q <= short_d;
        end
    end
    assign bus.o_wr      = wr_q;
    assign bus.o_waddr   = waddr_q;
    assign bus.o_wdata   = wdata_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;
    assign o_overflow    = ovf_q;
    assign o_short_frame = short_q;
    assign o_frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed vector table plus hand sequences for capture_ctrl on an 8x4 frame
module tb_capture_ctrl;
    localparam int H = 8, V = 4, AW = 5, SW = 4;
    typedef struct {
        logic start, abort, sof, wr, full;
        logic [15:0] wdata;
        logic e_wr;
        logic [AW-1:0] e_addr;
        logic [15:0] e_data;
        logic e_busy, e_done, e_ovf, e_short;
    } vec_t;
    logic i_pclk = 1'b0, i_rstn = 1'b0, i_start = 1'b0, i_continuous = 1'b0, i_abort = 1'b0;
    logic [SW-1:0] i_skip = '0;
    logic o_busy, o_frame_done, o_overflow, o_short_frame;
    logic [7:0] o_frame_cnt;
    int n_chk = 0, n_fail = 0;
    vec_t vt[16];
    capture_ctrl_if #(.ADDR_W(AW)) bus ();
    capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_W(SW)) dut (
        .i_pclk(i_pclk), .i_rstn(i_rstn), .i_start(i_start), .i_continuous(i_continuous),
        .i_abort(i_abort), .i_skip(i_skip), .bus(bus), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_overflow(o_overflow),
        .o_short_frame(o_short_frame), .o_frame_cnt(o_frame_cnt)
    );
    always #5 i_pclk = ~i_pclk;
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge i_pclk);
        #1;
    endtask
    task automatic drive(input logic st, input logic ab, input logic sof, input logic wr, input logic full, input logic [15:0] d);
        i_start = st;
        i_abort = ab;
        bus.i_sof = sof;
        bus.i_wr = wr;
        bus.i_full = full;
        bus.i_wdata = d;
        tick();
    endtask
    task automatic pix(input string tag, input int i, input logic [15:0] d, input logic f, input logic e_wr, input logic e_done);
        drive(1'b0, 1'b0, 1'b0, 1'b1, f, d);
        chk({tag, ".wr"}, i, bus.o_wr, e_wr);
        if (e_wr) begin
            chk({tag, ".addr"}, i, bus.o_waddr, i);
            chk({tag, ".data"}, i, bus.o_wdata, d);
        end
        chk({tag, ".done"}, i, o_frame_done, e_done);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [15:0] d;
        vt = '{
            '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,5'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0},
            '{1'b0,1'b0,1'b1,1'b1,1'b0,16'hAAAA, 1'b0,5'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0},
            '{1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0},
            '{1'b1,1'b0,1'b0,1'b1,1'b0,16'hBBBB, 1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0},
            '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h1111, 1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h1000, 1'b1,5'd0,16'h1000, 1'b1,1'b0,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h1001, 1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,1'b0},
            '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h1002, 1'b1,5'd2,16'h1002, 1'b1,1'b0,1'b1,1'b0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,1'b0},
            '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,1'b1},
            '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h2000, 1'b1,5'd0,16'h2000, 1'b1,1'b0,1'b1,1'b1},
            '{1'b0,1'b1,1'b0,1'b1,1'b0,16'h2001, 1'b0,5'd0,16'h0000, 1'b0,1'b0,1'b1,1'b1},
            '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h2002, 1'b0,5'd0,16'h0000, 1'b0,1'b0,1'b1,1'b1},
            '{1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b0,1'b0},
            '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,5'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0},
            '{1'b1,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,5'd0,16'h0000, 1'b0,1'b0,1'b0,1'b0}
        };
        bus.i_sof = 1'b0;
        bus.i_wr = 1'b0;
        bus.i_full = 1'b0;
        bus.i_wdata = '0;
        repeat (2) tick();
        chk("rst.wr", 0, bus.o_wr, 0);
        chk("rst.busy", 0, o_busy, 0);
        chk("rst.cnt", 0, o_frame_cnt, 0);
        i_rstn = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            drive(vt[k].start, vt[k].abort, vt[k].sof, vt[k].wr, vt[k].full, vt[k].wdata);
            chk("tab.wr", k, bus.o_wr, vt[k].e_wr);
            if (vt[k].e_wr) begin
                chk("tab.addr", k, bus.o_waddr, vt[k].e_addr);
                chk("tab.data", k, bus.o_wdata, vt[k].e_data);
            end
            chk("tab.busy", k, o_busy, vt[k].e_busy);
            chk("tab.done", k, o_frame_done, vt[k].e_done);
            chk("tab.ovf", k, o_overflow, vt[k].e_ovf);
            chk("tab.short", k, o_short_frame, vt[k].e_short);
            chk("tab.fcnt", k, o_frame_cnt, 0);
        end
        // single-shot frame, then a frame that must be ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < H * V; i++) begin
            d = 16'($urandom);
            pix("a_pix", i, d, 1'b0, 1'b1, i == H * V - 1);
        end
        chk("a.busy", 0, o_busy, 0);
        chk("a.fcnt", 0, o_frame_cnt, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < H * V; i++) pix("a_idle", i, 16'(i), 1'b0, 1'b0, 1'b0);
        // continuous with two skipped frames; continuous dropped mid frame 4
        i_continuous = 1'b1;
        i_skip = 4'd2;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int f = 0; f < 4; f++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            for (int i = 0; i < H * V; i++) begin
                if (f == 3 && i == 10) i_continuous = 1'b0;
                pix("b_pix", i, 16'(f * 256 + i), 1'b0, f == 0 || f == 3, (f == 0 || f == 3) && i == H * V - 1);
            end
            if (f == 0) chk("b.busy_skip", f, o_busy, 1);
        end
        chk("b.busy", 0, o_busy, 0);
        chk("b.fcnt", 0, o_frame_cnt, 3);
        i_skip = '0;
        // buffer full for pixels 5..7
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < H * V; i++)
            pix("c_pix", i, 16'h3000 + 16'(i), i >= 5 && i <= 7, !(i >= 5 && i <= 7), i == H * V - 1);
        chk("c.ovf", 0, o_overflow, 1);
        chk("c.fcnt", 0, o_frame_cnt, 4);
        // sof after 20 pixels restarts the frame
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("d.ovf_clr", 0, o_overflow, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 20; i++) pix("d_pre", i, 16'h4000 + 16'(i), 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("d.short", 0, o_short_frame, 1);
        for (int i = 0; i < H * V; i++) pix("d_post", i, 16'h5000 + 16'(i), 1'b0, 1'b1, i == H * V - 1);
        chk("d.fcnt", 0, o_frame_cnt, 5);
        // abort at pixel 10, then re-arm
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("e.short_clr", 0, o_short_frame, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) pix("e_pix", i, 16'h6000 + 16'(i), i == 3, i != 3, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h600A);
        chk("e.busy", 0, o_busy, 0);
        chk("e.done", 0, o_frame_done, 0);
        chk("e.ovf_kept", 0, o_overflow, 1);
        for (int i = 11; i < 16; i++) pix("e_post", i, 16'h6000 + 16'(i), 1'b0, 1'b0, 1'b0);
        chk("e.fcnt", 0, o_frame_cnt, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("e.rearm", 0, o_busy, 1);
        chk("e.ovf_clr", 0, o_overflow, 0);
        // asynchronous reset mid-capture
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) pix("f_pix", i, 16'h7000 + 16'(i), 1'b0, 1'b1, 1'b0);
        #2 i_rstn = 1'b0;
        #1;
        chk("f.wr", 0, bus.o_wr, 0);
        chk("f.addr", 0, bus.o_waddr, 0);
        chk("f.data", 0, bus.o_wdata, 0);
        chk("f.busy", 0, o_busy, 0);
        chk("f.fcnt", 0, o_frame_cnt, 0);
        i_rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, i[0], 1'b1, 1'b0, 16'h8000 + 16'(i));
            chk("f.post_wr", i, bus.o_wr, 0);
            chk("f.post_busy", i, o_busy, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
